// File: rtl/if_stage.sv
// Instruction fetch: PC, one outstanding imem request, one-entry buffer to decode.
// Latency: request addr combinational from pc; inst_valid rises the edge after rsp_valid.
// Backpressure: HOLD keeps inst/inst_addr stable and issues no fetch until id_ready.
//
// Ports:
//   clk, rst                 core clock, async active-low reset
//   inst_req_valid/addr/ready    imem request channel (4-byte aligned addr)
//   inst_rsp_valid/data          imem response, one-cycle pulse
//   inst_valid/inst/inst_addr    registered instruction to decode, id_ready consumes
//   redirect_valid/redirect_pc   branch/jump redirect from execute
//   halted                       termination instruction consumed, fetch stopped
module if_stage #(
  parameter logic [63:0] RESET_PC = 64'h0000_0000_8000_0000,
  parameter logic [31:0] NOP_INST = 32'h0000_0013
) (
  input  logic        clk,
  input  logic        rst,
  output logic        inst_req_valid,
  output logic [63:0] inst_req_addr,
  input  logic        inst_req_ready,
  input  logic        inst_rsp_valid,
  input  logic [31:0] inst_rsp_data,
  output logic        inst_valid,
  output logic [31:0] inst,
  output logic [63:0] inst_addr,
  input  logic        id_ready,
  input  logic        redirect_valid,
  input  logic [63:0] redirect_pc,
  output logic        halted
);

  localparam logic [6:0] HALT_OPCODE = 7'h6b;

  typedef enum logic [1:0] {REQ, WAIT, HOLD, HALT} state_t;

  state_t      state, state_n;
  logic [63:0] pc, pc_n;
  logic        kill, kill_n;
  logic        inst_valid_n;
  logic [31:0] inst_n;
  logic [63:0] inst_addr_n;
  logic        halted_n;

  logic        req_fire;
  logic [63:0] redirect_target;

  assign inst_req_valid  = (state == REQ) & rst;
  assign inst_req_addr   = pc;
  assign req_fire        = inst_req_valid & inst_req_ready;
  assign redirect_target = redirect_pc & ~64'h3;

  always_comb begin
    state_n      = state;
    pc_n         = pc;
    kill_n       = kill;
    inst_valid_n = inst_valid;
    inst_n       = inst;
    inst_addr_n  = inst_addr;
    halted_n     = halted;

    case (state)
      REQ: begin
        if (redirect_valid) begin
          pc_n = redirect_target;
          // The request already sent went to the old pc; mark it wrong-path.
          if (req_fire) begin
            state_n = WAIT;
            kill_n  = 1'b1;
          end
        end else if (req_fire) begin
          state_n = WAIT;
        end
      end

      WAIT: begin
        if (redirect_valid) begin
          pc_n = redirect_target;
          if (inst_rsp_valid) begin
            kill_n  = 1'b0;
            state_n = REQ;
          end else begin
            kill_n = 1'b1;
          end
        end else if (inst_rsp_valid) begin
          if (kill) begin
            kill_n  = 1'b0;
            state_n = REQ;
          end else begin
            inst_n       = inst_rsp_data;
            inst_addr_n  = pc;
            inst_valid_n = 1'b1;
            state_n      = HOLD;
          end
        end
      end

      HOLD: begin
        if (redirect_valid) begin
          // Buffered instruction is wrong-path even if decode takes it now.
          pc_n         = redirect_target;
          inst_valid_n = 1'b0;
          inst_n       = NOP_INST;
          state_n      = REQ;
        end else if (id_ready) begin
          inst_valid_n = 1'b0;
          inst_n       = NOP_INST;
          if (inst[6:0] == HALT_OPCODE) begin
            state_n  = HALT;
            halted_n = 1'b1;
          end else begin
            pc_n    = pc + 64'd4;
            state_n = REQ;
          end
        end
      end

      HALT: begin
        state_n = HALT;
      end

      default: begin
        state_n = REQ;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state      <= REQ;
      pc         <= RESET_PC;
      kill       <= 1'b0;
      inst_valid <= 1'b0;
      inst       <= NOP_INST;
      inst_addr  <= 64'd0;
      halted     <= 1'b0;
    end else begin
      state      <= state_n;
      pc         <= pc_n;
      kill       <= kill_n;
      inst_valid <= inst_valid_n;
      inst       <= inst_n;
      inst_addr  <= inst_addr_n;
      halted     <= halted_n;
    end
  end

endmodule
